irs_wilkinson_monitor_multi: RTL and testbench
==============================================

Name: irs_wilkinson_monitor_multi

Overview:
- Multi-channel successor to the single-IRS Wilkinson test-counter monitor.
- Runs one shared measurement sequencer over NUM_CH IRS test counters. Each channel counts TSTOUT rising edges over a fixed clock window.
- Adds the following over the single-channel block: arm timeout, counter saturation, threshold alarms, and one-shot/periodic modes.
- Sits between the IRS control block (start/clear strobes) and the register/servo logic that reads the latched counts.

Parameters:
NUM_CH, 4, number of monitored IRS channels
CNT_WIDTH, 12, per-channel edge-count width
WINDOW, 69636, counting window length in clk_i cycles
WINDOW_WIDTH, 17, width of window counter (must hold WINDOW)
ARM_TIMEOUT, 1024, cycles allowed in ARM before declaring a stuck channel set
IDLE_TICKS, 16, KHz ticks between periodic measurements

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  asynchronous active-low reset
enable_i  in  1  global monitor enable
present_i  in  NUM_CH  per-channel IRS present mask
is_init_i  in  1  IRS initialisation complete
KHz_clk_i  in  1  one-cycle 1 kHz tick
oneshot_i  in  1  1 = measure only on trigger_i; 0 = periodic
trigger_i  in  1  one-cycle measurement request (oneshot mode)
low_thr_i  in  CNT_WIDTH  alarm low threshold
high_thr_i  in  CNT_WIDTH  alarm high threshold
test_wilk_out_i  in  NUM_CH  async TSTOUT per channel
test_wilk_start_o  out  NUM_CH  TSTST strobe (present channels only)
test_wilk_clear_o  out  NUM_CH  TSTCLR strobe (present channels only)
count_o  out  NUM_CH*CNT_WIDTH  latched counts, channel 0 in LSBs
count_done_o  out  1  one-cycle pulse, new counts valid
overflow_o  out  NUM_CH  latched saturation flag
alarm_o  out  NUM_CH  latched: count < low_thr_i or count > high_thr_i
timeout_o  out  1  latched: ARM timed out
state_o  out  4  current state, debug

Behaviour:
- Reset (rst_n_i low, async): state=OFF; all outputs 0; counters, latches and flags 0.
- Input sync: test_wilk_out_i passes through two flops per channel, then a rising-edge register. An edge reaches its counter 3 cycles after the input transition.
- States: OFF, CLEAR, START, ARM, COUNT, LATCH, DONE, WAIT.
- OFF -> CLEAR when enable_i && is_init_i && |present_i.
- CLEAR (1 cycle): clear_o = present_i. Next state is START on the first pass after enable. Otherwise it is WAIT.
- START (1 cycle): start_o = present_i; all edge counters zeroed.
- ARM: leave on the synchronized high of any present channel -> COUNT, window counter zeroed.
  - Timeout: ARM_TIMEOUT cycles without that high -> LATCH with timeout flag set; counts latched as 0.
- COUNT: window counter increments each cycle. On reaching WINDOW-1 (exactly WINDOW cycles) -> LATCH.
  - Edges on a present channel increment its counter. A counter stuck at all-ones stays there and sets that channel's sticky overflow.
- LATCH (1 cycle): count_o, overflow_o and timeout_o are updated.
  - alarm_o[n] = present[n] && (cnt<low_thr_i || cnt>high_thr_i), unsigned compare.
  - Non-present channels latch count 0, alarm 0, overflow 0.
- DONE (1 cycle): count_done_o=1 -> CLEAR.
- WAIT, periodic mode (oneshot_i=0): count KHz_clk_i ticks; the IDLE_TICKS-th tick -> START. The tick counter clears on entry.
- WAIT, oneshot mode (oneshot_i=1): trigger_i -> START; ticks are ignored. If trigger_i and a tick arrive in the same cycle while oneshot_i=1, the trigger wins.
- trigger_i outside WAIT is ignored (not queued).
- enable_i low or present_i all-zero in any state: next cycle -> OFF. First-pass flag clears.
  - Latched outputs hold their last values.
  - A one-cycle clear_o = previous present_i is issued on the enable_i falling edge.
- present_i change mid-measurement: strobes use the current mask. A channel dropped during COUNT latches 0.
- Thresholds are sampled only in LATCH. If low_thr_i > high_thr_i, every present channel alarms.

Test Plan:
- Periodic, 4 channels, TSTOUT period 100 clk -> counts 696 or 697 each; count_done_o pulses once per 16 KHz ticks; alarm_o=0 with thr 600/800.
- Channel 2 TSTOUT held low, others toggling -> counts latch normally; alarm_o[2]=1 with low_thr=1.
- All TSTOUT held low -> timeout_o=1 after 1024 ARM cycles; all counts 0; count_done_o still pulses.
- TSTOUT toggling every cycle pair with CNT_WIDTH=12 -> count_o=4095 and overflow_o=1 on toggling channels.
- Oneshot mode -> no measurement until trigger_i; a trigger during COUNT is ignored; a trigger in WAIT gives exactly one count_done_o.
- Deassert enable_i mid-COUNT -> state OFF next cycle; one clear_o pulse on present channels; count_o unchanged. Async reset mid-COUNT -> all outputs 0 immediately.

Source files
------------

// File: rtl/irs_wilkinson_monitor_multi.sv
// Multi-channel IRS Wilkinson test-counter monitor: one shared sequencer counts
// TSTOUT rising edges per channel over a fixed window and latches counts/alarms.
module irs_wilkinson_monitor_multi #(
  parameter int NUM_CH       = 4,
  parameter int CNT_WIDTH    = 12,
  parameter int WINDOW       = 69636,
  parameter int WINDOW_WIDTH = 17,
  parameter int ARM_TIMEOUT  = 1024,
  parameter int IDLE_TICKS   = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          enable_i,
  input  logic [NUM_CH-1:0]             present_i,
  input  logic                          is_init_i,
  input  logic                          KHz_clk_i,
  input  logic                          oneshot_i,
  input  logic                          trigger_i,
  input  logic [CNT_WIDTH-1:0]          low_thr_i,
  input  logic [CNT_WIDTH-1:0]          high_thr_i,
  input  logic [NUM_CH-1:0]             test_wilk_out_i,
  output logic [NUM_CH-1:0]             test_wilk_start_o,
  output logic [NUM_CH-1:0]             test_wilk_clear_o,
  output logic [NUM_CH*CNT_WIDTH-1:0]   count_o,
  output logic                          count_done_o,
  output logic [NUM_CH-1:0]             overflow_o,
  output logic [NUM_CH-1:0]             alarm_o,
  output logic                          timeout_o,
  output logic [3:0]                    state_o
);

  typedef enum logic [3:0] {
    S_OFF   = 4'd0,
    S_CLEAR = 4'd1,
    S_START = 4'd2,
    S_ARM   = 4'd3,
    S_COUNT = 4'd4,
    S_LATCH = 4'd5,
    S_DONE  = 4'd6,
    S_WAIT  = 4'd7
  } state_t;

  localparam int ARM_W  = $clog2(ARM_TIMEOUT + 1);
  localparam int TICK_W = $clog2(IDLE_TICKS + 1);
  localparam logic [WINDOW_WIDTH-1:0] WIN_LAST  = WINDOW_WIDTH'(WINDOW - 1);
  localparam logic [ARM_W-1:0]        ARM_LAST  = ARM_W'(ARM_TIMEOUT - 1);
  localparam logic [TICK_W-1:0]       TICK_LAST = TICK_W'(IDLE_TICKS - 1);
  localparam logic [CNT_WIDTH-1:0]    CNT_MAX   = '1;

  state_t                   r_state;
  state_t                   w_next;
  logic [NUM_CH-1:0]        r_sync1;
  logic [NUM_CH-1:0]        r_sync2;
  logic [NUM_CH-1:0]        r_sync3;
  logic [NUM_CH-1:0]        r_edge;
  logic [CNT_WIDTH-1:0]     r_cnt [NUM_CH];
  logic [NUM_CH-1:0]        r_ovf;
  logic [WINDOW_WIDTH-1:0]  r_win;
  logic [ARM_W-1:0]         r_arm;
  logic [TICK_W-1:0]        r_tick;
  logic                     r_first;
  logic                     r_tmo;
  logic                     r_en_d;
  logic [NUM_CH-1:0]        r_pres_d;
  logic [NUM_CH*CNT_WIDTH-1:0] r_count;
  logic [NUM_CH-1:0]        r_ovf_o;
  logic [NUM_CH-1:0]        r_alarm;
  logic                     r_timeout;

  logic                     w_active;
  logic                     w_armed;
  logic [CNT_WIDTH-1:0]     w_lcnt [NUM_CH];
  logic [NUM_CH-1:0]        w_alarm;
  logic [NUM_CH-1:0]        w_ovf;

  assign w_active = enable_i && (|present_i);
  assign w_armed  = |(r_sync2 & present_i);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_OFF;
    end else begin
      r_state <= w_next;
    end
  end

  // Losing enable or every present bit aborts from any state.
  always_comb begin
    w_next = r_state;
    if (r_state != S_OFF && !w_active) begin
      w_next = S_OFF;
    end else begin
      case (r_state)
        S_OFF:   if (w_active && is_init_i) w_next = S_CLEAR;
        S_CLEAR: w_next = r_first ? S_START : S_WAIT;
        S_START: w_next = S_ARM;
        S_ARM: begin
          if (w_armed) w_next = S_COUNT;
          else if (r_arm == ARM_LAST) w_next = S_LATCH;
        end
        S_COUNT: if (r_win == WIN_LAST) w_next = S_LATCH;
        S_LATCH: w_next = S_DONE;
        S_DONE:  w_next = S_CLEAR;
        S_WAIT: begin
          if (oneshot_i) begin
            if (trigger_i) w_next = S_START;
          end else if (KHz_clk_i && r_tick == TICK_LAST) begin
            w_next = S_START;
          end
        end
        default: w_next = S_OFF;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_sync3 <= '0;
      r_edge  <= '0;
    end else begin
      r_sync1 <= test_wilk_out_i;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_edge  <= r_sync2 & ~r_sync3;
    end
  end

  // Edge counters saturate at all-ones and flag the overflow until next START.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int n = 0; n < NUM_CH; n++) r_cnt[n] <= '0;
      r_ovf <= '0;
    end else if (r_state == S_START) begin
      for (int n = 0; n < NUM_CH; n++) r_cnt[n] <= '0;
      r_ovf <= '0;
    end else if (r_state == S_COUNT) begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (r_edge[n] && present_i[n]) begin
          if (r_cnt[n] == CNT_MAX) r_ovf[n] <= 1'b1;
          else r_cnt[n] <= r_cnt[n] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_win    <= '0;
      r_arm    <= '0;
      r_tick   <= '0;
      r_first  <= 1'b0;
      r_tmo    <= 1'b0;
      r_en_d   <= 1'b0;
      r_pres_d <= '0;
    end else begin
      r_win    <= (r_state == S_COUNT) ? r_win + 1'b1 : '0;
      r_arm    <= (r_state == S_ARM) ? r_arm + 1'b1 : '0;
      r_en_d   <= enable_i;
      r_pres_d <= present_i;
      if (r_state != S_WAIT) r_tick <= '0;
      else if (!oneshot_i && KHz_clk_i) r_tick <= r_tick + 1'b1;
      if (w_next == S_OFF) r_first <= 1'b0;
      else if (r_state == S_OFF && w_next == S_CLEAR) r_first <= 1'b1;
      else if (r_state == S_CLEAR) r_first <= 1'b0;
      if (r_state == S_START) r_tmo <= 1'b0;
      else if (r_state == S_ARM && w_next == S_LATCH) r_tmo <= 1'b1;
    end
  end

  // A timed-out or non-present channel reports a zero count.
  always_comb begin
    w_alarm = '0;
    w_ovf   = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      w_lcnt[n]  = (present_i[n] && !r_tmo) ? r_cnt[n] : '0;
      w_alarm[n] = present_i[n] && ((w_lcnt[n] < low_thr_i) || (w_lcnt[n] > high_thr_i));
      w_ovf[n]   = present_i[n] && !r_tmo && r_ovf[n];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_count   <= '0;
      r_ovf_o   <= '0;
      r_alarm   <= '0;
      r_timeout <= 1'b0;
    end else if (r_state == S_LATCH) begin
      for (int n = 0; n < NUM_CH; n++) r_count[n*CNT_WIDTH +: CNT_WIDTH] <= w_lcnt[n];
      r_ovf_o   <= w_ovf;
      r_alarm   <= w_alarm;
      r_timeout <= r_tmo;
    end
  end

  assign test_wilk_start_o = (r_state == S_START) ? present_i : '0;
  assign test_wilk_clear_o = ((r_state == S_CLEAR) ? present_i : '0) |
                             ((r_en_d && !enable_i) ? r_pres_d : '0);
  assign count_done_o = (r_state == S_DONE);
  assign count_o      = r_count;
  assign overflow_o   = r_ovf_o;
  assign alarm_o      = r_alarm;
  assign timeout_o    = r_timeout;
  assign state_o      = r_state;

endmodule

// File: tb/tb_irs_wilkinson_monitor_multi.sv
// Directed bench for irs_wilkinson_monitor_multi with a shortened window so each
// measurement is ~130 cycles; expected counts follow from fixed TSTOUT periods.
module tb_irs_wilkinson_monitor_multi;

  localparam int NCH = 4;
  localparam int CW  = 5;
  localparam logic [3:0] ST_OFF = 4'd0, ST_CLEAR = 4'd1, ST_START = 4'd2, ST_ARM = 4'd3;
  localparam logic [3:0] ST_COUNT = 4'd4, ST_LATCH = 4'd5, ST_WAIT = 4'd7;
  // Window 100 with periods 10/20/4/50 gives exactly 10/5/25/2 edges at any phase.
  localparam logic [19:0] EXP_BASE = {5'd2, 5'd25, 5'd5, 5'd10};
  localparam logic [19:0] EXP_LOW  = {5'd0, 5'd0, 5'd5, 5'd10};
  localparam logic [19:0] EXP_OVF  = {5'd2, 5'd25, 5'd5, 5'd31};

  logic clk_i = 1'b0;
  logic rst_n_i = 1'b0;
  logic enable_i = 1'b0;
  logic [NCH-1:0] present_i = '0;
  logic is_init_i = 1'b0;
  logic khzTick = 1'b0;
  logic oneshot_i = 1'b0;
  logic trigger_i = 1'b0;
  logic [CW-1:0] low_thr_i = '0;
  logic [CW-1:0] high_thr_i = '0;
  logic [NCH-1:0] tstOut = '0;
  logic [NCH-1:0] test_wilk_start_o;
  logic [NCH-1:0] test_wilk_clear_o;
  logic [NCH*CW-1:0] count_o;
  logic count_done_o;
  logic [NCH-1:0] overflow_o;
  logic [NCH-1:0] alarm_o;
  logic timeout_o;
  logic [3:0] state_o;

  logic [NCH-1:0] genEn = '0;
  int halfPer [NCH];
  int genCnt [NCH];
  int tickCnt = 0;
  int testsRun = 0;
  int testsFailed = 0;

  irs_wilkinson_monitor_multi #(
    .NUM_CH(NCH), .CNT_WIDTH(CW), .WINDOW(100), .WINDOW_WIDTH(7),
    .ARM_TIMEOUT(20), .IDLE_TICKS(3)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .enable_i(enable_i), .present_i(present_i),
    .is_init_i(is_init_i), .KHz_clk_i(khzTick), .oneshot_i(oneshot_i),
    .trigger_i(trigger_i), .low_thr_i(low_thr_i), .high_thr_i(high_thr_i),
    .test_wilk_out_i(tstOut), .test_wilk_start_o(test_wilk_start_o),
    .test_wilk_clear_o(test_wilk_clear_o), .count_o(count_o),
    .count_done_o(count_done_o), .overflow_o(overflow_o), .alarm_o(alarm_o),
    .timeout_o(timeout_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  // Free-running TSTOUT and kHz-tick sources, updated on the clock edge.
  always @(posedge clk_i) begin
    for (int n = 0; n < NCH; n++) begin
      if (genEn[n]) begin
        if (genCnt[n] >= halfPer[n] - 1) begin
          genCnt[n] <= 0;
          tstOut[n] <= ~tstOut[n];
        end else begin
          genCnt[n] <= genCnt[n] + 1;
        end
      end else begin
        tstOut[n] <= 1'b0;
      end
    end
    tickCnt <= (tickCnt == 7) ? 0 : tickCnt + 1;
    khzTick <= (tickCnt == 7);
  end

  task automatic waitState(input logic [3:0] s, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk_i); #1;
      if (state_o == s) begin ok = 1'b1; break; end
    end
  endtask

  task automatic waitDone(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk_i); #1;
      if (count_done_o) begin ok = 1'b1; break; end
    end
  endtask

  task automatic pulseTrigger();
    trigger_i = 1'b1;
    @(posedge clk_i); #1;
    trigger_i = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_i);
    #1;
    testsRun++;
    if (state_o !== ST_OFF) begin testsFailed++; $display("[TB] FAIL reset_state: got %0d, want %0d", state_o, ST_OFF); end
    testsRun++;
    if (count_o !== '0 || count_done_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_count: got %h/%b, want 0/0", count_o, count_done_o); end
    testsRun++;
    if ({overflow_o, alarm_o, timeout_o} !== '0) begin testsFailed++; $display("[TB] FAIL reset_flags: got %b %b %b, want 0", overflow_o, alarm_o, timeout_o); end
    testsRun++;
    if ({test_wilk_start_o, test_wilk_clear_o} !== '0) begin testsFailed++; $display("[TB] FAIL reset_strobes: got %b %b, want 0", test_wilk_start_o, test_wilk_clear_o); end
    rst_n_i = 1'b1;
  endtask

  task automatic test_periodic();
    bit ok;
    int ticks;
    int guard;
    present_i = 4'hF; is_init_i = 1'b1; oneshot_i = 1'b0;
    low_thr_i = 5'd3; high_thr_i = 5'd20;
    halfPer = '{5, 10, 2, 25};
    genEn = 4'hF;
    repeat (4) @(posedge clk_i);
    #1 enable_i = 1'b1;
    waitState(ST_CLEAR, 5, ok);
    testsRun++;
    if (!ok || test_wilk_clear_o !== 4'hF) begin testsFailed++; $display("[TB] FAIL first_clear: got ok=%0d clear=%b, want 1 1111", ok, test_wilk_clear_o); end
    waitState(ST_START, 5, ok);
    testsRun++;
    if (!ok || test_wilk_start_o !== 4'hF) begin testsFailed++; $display("[TB] FAIL first_start: got ok=%0d start=%b, want 1 1111", ok, test_wilk_start_o); end
    waitDone(300, ok);
    testsRun++;
    if (!ok || count_o !== EXP_BASE) begin testsFailed++; $display("[TB] FAIL periodic_count: got ok=%0d %h, want %h", ok, count_o, EXP_BASE); end
    testsRun++;
    if (alarm_o !== 4'b1100 || overflow_o !== 4'b0000 || timeout_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL periodic_flags: got %b %b %b, want 1100 0000 0", alarm_o, overflow_o, timeout_o); end
    waitState(ST_WAIT, 5, ok);
    ticks = 0; guard = 0;
    while (state_o == ST_WAIT && guard < 200) begin
      if (khzTick) ticks++;
      @(posedge clk_i); #1;
      guard++;
    end
    testsRun++;
    if (!ok || state_o !== ST_START || ticks != 3) begin testsFailed++; $display("[TB] FAIL wait_ticks: got ok=%0d state=%0d ticks=%0d, want 1 2 3", ok, state_o, ticks); end
    waitDone(300, ok);
    testsRun++;
    if (!ok || count_o !== EXP_BASE) begin testsFailed++; $display("[TB] FAIL periodic_count2: got ok=%0d %h, want %h", ok, count_o, EXP_BASE); end
  endtask

  task automatic test_channel_low();
    bit ok;
    present_i = 4'b0111; genEn = 4'b1011;
    low_thr_i = 5'd1; high_thr_i = 5'd30;
    waitState(ST_START, 300, ok);
    testsRun++;
    if (!ok || test_wilk_start_o !== 4'b0111) begin testsFailed++; $display("[TB] FAIL masked_start: got ok=%0d %b, want 1 0111", ok, test_wilk_start_o); end
    waitDone(300, ok);
    testsRun++;
    if (!ok || count_o !== EXP_LOW) begin testsFailed++; $display("[TB] FAIL chlow_count: got ok=%0d %h, want %h", ok, count_o, EXP_LOW); end
    testsRun++;
    if (alarm_o !== 4'b0100 || overflow_o !== 4'b0000) begin testsFailed++; $display("[TB] FAIL chlow_alarm: got %b %b, want 0100 0000", alarm_o, overflow_o); end
  endtask

  task automatic test_overflow();
    bit ok;
    present_i = 4'hF; genEn = 4'hF;
    halfPer = '{1, 10, 2, 25};
    waitDone(300, ok);
    testsRun++;
    if (!ok || count_o !== EXP_OVF) begin testsFailed++; $display("[TB] FAIL ovf_count: got ok=%0d %h, want %h", ok, count_o, EXP_OVF); end
    testsRun++;
    if (overflow_o !== 4'b0001 || alarm_o !== 4'b0001) begin testsFailed++; $display("[TB] FAIL ovf_flags: got %b %b, want 0001 0001", overflow_o, alarm_o); end
  endtask

  task automatic test_timeout();
    bit ok;
    int armCycles;
    genEn = 4'h0;
    low_thr_i = 5'd3; high_thr_i = 5'd20;
    waitState(ST_ARM, 300, ok);
    armCycles = 0;
    while (state_o == ST_ARM && armCycles < 100) begin
      armCycles++;
      @(posedge clk_i); #1;
    end
    testsRun++;
    if (!ok || armCycles != 20 || state_o !== ST_LATCH) begin testsFailed++; $display("[TB] FAIL arm_length: got ok=%0d cycles=%0d state=%0d, want 1 20 5", ok, armCycles, state_o); end
    waitDone(10, ok);
    testsRun++;
    if (!ok || count_o !== '0 || timeout_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL timeout_latch: got ok=%0d %h to=%b, want 1 0 1", ok, count_o, timeout_o); end
    testsRun++;
    if (alarm_o !== 4'hF || overflow_o !== 4'h0) begin testsFailed++; $display("[TB] FAIL timeout_flags: got %b %b, want 1111 0000", alarm_o, overflow_o); end
  endtask

  task automatic test_oneshot();
    bit ok;
    int dones;
    oneshot_i = 1'b1; genEn = 4'hF;
    halfPer = '{5, 10, 2, 25};
    waitState(ST_WAIT, 10, ok);
    dones = 0;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk_i); #1;
      if (count_done_o) dones++;
    end
    testsRun++;
    if (!ok || dones != 0 || state_o !== ST_WAIT) begin testsFailed++; $display("[TB] FAIL oneshot_idle: got ok=%0d dones=%0d state=%0d, want 1 0 7", ok, dones, state_o); end
    pulseTrigger();
    waitState(ST_COUNT, 60, ok);
    testsRun++;
    if (!ok) begin testsFailed++; $display("[TB] FAIL oneshot_start: got state %0d, want %0d", state_o, ST_COUNT); end
    pulseTrigger();
    dones = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk_i); #1;
      if (count_done_o) dones++;
    end
    testsRun++;
    if (dones != 1) begin testsFailed++; $display("[TB] FAIL oneshot_dones: got %0d, want 1", dones); end
    testsRun++;
    if (count_o !== EXP_BASE || timeout_o !== 1'b0 || alarm_o !== 4'b1100) begin testsFailed++; $display("[TB] FAIL oneshot_result: got %h %b %b, want %h 0 1100", count_o, timeout_o, alarm_o, EXP_BASE); end
  endtask

  task automatic test_disable();
    bit ok;
    testsRun++;
    if (state_o !== ST_WAIT) begin testsFailed++; $display("[TB] FAIL disable_pre: got state %0d, want %0d", state_o, ST_WAIT); end
    pulseTrigger();
    waitState(ST_COUNT, 60, ok);
    repeat (10) @(posedge clk_i);
    #1 enable_i = 1'b0;
    #1;
    testsRun++;
    if (!ok || test_wilk_clear_o !== 4'hF || state_o !== ST_COUNT) begin testsFailed++; $display("[TB] FAIL disable_clear: got ok=%0d clear=%b state=%0d, want 1 1111 4", ok, test_wilk_clear_o, state_o); end
    @(posedge clk_i); #1;
    testsRun++;
    if (state_o !== ST_OFF || test_wilk_clear_o !== 4'h0) begin testsFailed++; $display("[TB] FAIL disable_off: got state=%0d clear=%b, want 0 0000", state_o, test_wilk_clear_o); end
    testsRun++;
    if (count_o !== EXP_BASE || alarm_o !== 4'b1100 || count_done_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL disable_hold: got %h %b %b, want %h 1100 0", count_o, alarm_o, count_done_o, EXP_BASE); end
  endtask

  task automatic test_async_reset();
    bit ok;
    oneshot_i = 1'b0;
    @(posedge clk_i); #1;
    enable_i = 1'b1;
    waitState(ST_COUNT, 60, ok);
    testsRun++;
    if (!ok) begin testsFailed++; $display("[TB] FAIL reenable_count: got state %0d, want %0d", state_o, ST_COUNT); end
    #3 rst_n_i = 1'b0;
    #1;
    testsRun++;
    if (state_o !== ST_OFF || count_o !== '0 || count_done_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL areset_state: got %0d %h %b, want 0 0 0", state_o, count_o, count_done_o); end
    testsRun++;
    if ({alarm_o, overflow_o, timeout_o, test_wilk_start_o, test_wilk_clear_o} !== '0) begin testsFailed++; $display("[TB] FAIL areset_flags: got %b %b %b %b %b, want 0", alarm_o, overflow_o, timeout_o, test_wilk_start_o, test_wilk_clear_o); end
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
  endtask

  initial begin
    for (int n = 0; n < NCH; n++) begin
      halfPer[n] = 5;
      genCnt[n] = 0;
    end
    test_reset();
    test_periodic();
    test_channel_low();
    test_overflow();
    test_timeout();
    test_oneshot();
    test_disable();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
